// File: rtl/bp_fe_pkg.sv
// Package shared by the FE parcel realigner and its parcel queue.
// Holds the parcel width, the queue entry type and the RVC length decode.
package bp_fe_pkg;

  localparam int parcel_width_lp = 16;

  // tag marks the first parcel written from an I$ block (or a resume parcel),
  // so the top level can tell when a 32-bit instruction crosses two blocks.
  typedef struct packed {
    logic                        tag;
    logic [parcel_width_lp-1:0]  data;
  } bp_fe_parcel_entry_s;

  function automatic logic is_compressed(input logic [parcel_width_lp-1:0] p);
    return (p[1:0] != 2'b11);
  endfunction

endpackage

// File: rtl/bp_fe_parcel_queue.sv
// Circular parcel buffer.
//   clear_i      : drop contents; a same-cycle write lands at index 0
//   wr_n_i       : number of parcels (0..fetch_parcels_p) taken from wr_data_i[0..]
//   rd_n_i       : parcels popped from head (0..2), ignored when clear_i
//   h0_o / h1_o  : the two parcels at head
//   count_o      : occupancy
module bp_fe_parcel_queue
  import bp_fe_pkg::*;
#(
  parameter int fetch_parcels_p  = 4,
  parameter int buffer_parcels_p = 8,
  localparam int ptr_w_lp = $clog2(buffer_parcels_p),
  localparam int cnt_w_lp = ptr_w_lp + 1,
  localparam int wn_w_lp  = $clog2(fetch_parcels_p) + 1
) (
  input  logic                                      clk_i,
  input  logic                                      reset_n_i,
  input  logic                                      clear_i,
  input  logic [wn_w_lp-1:0]                        wr_n_i,
  input  bp_fe_parcel_entry_s [fetch_parcels_p-1:0] wr_data_i,
  input  logic [1:0]                                rd_n_i,
  output bp_fe_parcel_entry_s                       h0_o,
  output bp_fe_parcel_entry_s                       h1_o,
  output logic [cnt_w_lp-1:0]                       count_o
);

  bp_fe_parcel_entry_s r_mem [buffer_parcels_p];
  logic [ptr_w_lp-1:0] r_head, r_tail;
  logic [cnt_w_lp-1:0] r_count;

  logic [ptr_w_lp-1:0] w_base;
  logic [ptr_w_lp-1:0] w_widx [fetch_parcels_p];
  logic                w_wen  [fetch_parcels_p];
  logic [1:0]          w_rd_n;

  assign w_base = clear_i ? '0 : r_tail;
  assign w_rd_n = clear_i ? 2'd0 : rd_n_i;

  always_comb begin
    for (int k = 0; k < fetch_parcels_p; k++) begin
      w_widx[k] = w_base + ptr_w_lp'(k);
      w_wen[k]  = (wn_w_lp'(k) < wr_n_i);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < buffer_parcels_p; i++) r_mem[i] <= '0;
    end else begin
      for (int k = 0; k < fetch_parcels_p; k++)
        if (w_wen[k]) r_mem[w_widx[k]] <= wr_data_i[k];
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (clear_i) begin
      r_head  <= '0;
      r_tail  <= ptr_w_lp'(wr_n_i);
      r_count <= cnt_w_lp'(wr_n_i);
    end else begin
      r_head  <= r_head + ptr_w_lp'(w_rd_n);
      r_tail  <= r_tail + ptr_w_lp'(wr_n_i);
      r_count <= r_count + cnt_w_lp'(wr_n_i) - cnt_w_lp'(w_rd_n);
    end
  end

  assign h0_o    = r_mem[r_head];
  assign h1_o    = r_mem[r_head + ptr_w_lp'(1)];
  assign count_o = r_count;

endmodule

// File: rtl/bp_fe_parcel_realigner.sv
// FE parcel realigner: buffers 16-bit parcels from multi-parcel I$ blocks and
// emits one 16/32-bit instruction per cycle on a valid/yumi handshake.
// Ports:
//   if2_*      : fetch block in (pc of first valid parcel, data block-aligned)
//   redirect_* : flush, optionally reloading one saved parcel
//   fetch_*    : instruction / exception out, taken by fetch_yumi_i
//   count_o    : queue occupancy in parcels
module bp_fe_parcel_realigner
  import bp_fe_pkg::*;
#(
  parameter int vaddr_width_p    = 39,
  parameter int fetch_parcels_p  = 4,
  parameter int buffer_parcels_p = 8,
  localparam int cnt_w_lp = $clog2(buffer_parcels_p) + 1,
  localparam int off_w_lp = $clog2(fetch_parcels_p),
  localparam int wn_w_lp  = off_w_lp + 1
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic                            if2_v_i,
  input  logic                            if2_exception_v_i,
  input  logic [vaddr_width_p-1:0]        if2_pc_i,
  input  logic [16*fetch_parcels_p-1:0]   if2_data_i,
  output logic                            if2_ready_o,
  input  logic                            redirect_v_i,
  input  logic                            redirect_resume_i,
  input  logic [15:0]                     redirect_instr_i,
  input  logic [vaddr_width_p-1:0]        redirect_pc_i,
  output logic                            fetch_v_o,
  output logic                            fetch_exception_v_o,
  output logic [vaddr_width_p-1:0]        fetch_pc_o,
  output logic [31:0]                     fetch_instr_o,
  output logic                            fetch_compressed_o,
  output logic                            fetch_partial_o,
  input  logic                            fetch_yumi_i,
  output logic [cnt_w_lp-1:0]             count_o
);

  logic [vaddr_width_p-1:0] r_head_pc, r_exc_pc;
  logic                     r_exc_pending;

  bp_fe_parcel_entry_s                       w_h0, w_h1;
  logic [cnt_w_lp-1:0]                       w_count;
  bp_fe_parcel_entry_s [fetch_parcels_p-1:0] w_blk_ent, w_wr_ent;
  logic [16*fetch_parcels_p-1:0]             w_shift;
  logic [off_w_lp-1:0]                       w_off;
  logic [wn_w_lp-1:0]                        w_n_in, w_wr_n;
  logic                                      w_compressed, w_instr_v, w_exc_out;
  logic [1:0]                                w_need, w_rd_n;
  logic                                      w_accept, w_wr_blk, w_yumi_instr, w_yumi_exc, w_clear;

  // Decode from head
  assign w_compressed = is_compressed(w_h0.data);
  assign w_need       = w_compressed ? 2'd1 : 2'd2;
  assign w_instr_v    = (w_count >= cnt_w_lp'(w_need));
  // Complete instructions ahead of the fault drain before it is reported
  assign w_exc_out    = r_exc_pending & ~w_instr_v;

  assign fetch_v_o           = w_instr_v;
  assign fetch_exception_v_o = w_exc_out;
  assign fetch_compressed_o  = w_compressed;
  assign fetch_instr_o       = w_compressed ? {16'b0, w_h0.data} : {w_h1.data, w_h0.data};
  // A lone leftover parcel means the faulting fetch cut an instruction in half:
  // report it at the instruction's pc.
  assign fetch_pc_o      = (w_exc_out && (w_count != cnt_w_lp'(1))) ? r_exc_pc : r_head_pc;
  assign fetch_partial_o = w_exc_out ? (w_count == cnt_w_lp'(1)) : (~w_compressed & w_h1.tag);

  assign if2_ready_o = ((cnt_w_lp'(buffer_parcels_p) - w_count) >= cnt_w_lp'(fetch_parcels_p))
                     & ~r_exc_pending & ~redirect_v_i;

  // Redirect outranks everything; if2_ready_o already masks the write
  assign w_accept     = if2_v_i & if2_ready_o;
  assign w_wr_blk     = w_accept & ~if2_exception_v_i;
  assign w_yumi_instr = fetch_yumi_i & w_instr_v & ~redirect_v_i;
  assign w_yumi_exc   = fetch_yumi_i & w_exc_out & ~redirect_v_i;
  assign w_clear      = redirect_v_i | w_yumi_exc;

  // Drop leading parcels below the entry pc so parcel `off` lands at slot 0
  assign w_off   = if2_pc_i[1+:off_w_lp];
  assign w_n_in  = wn_w_lp'(fetch_parcels_p) - wn_w_lp'(w_off);
  assign w_shift = if2_data_i >> {w_off, 4'b0};

  always_comb begin
    for (int k = 0; k < fetch_parcels_p; k++) begin
      w_blk_ent[k].data = w_shift[16*k +: 16];
      w_blk_ent[k].tag  = (k == 0);
    end
  end

  always_comb begin
    w_wr_ent = w_blk_ent;
    w_wr_n   = w_wr_blk ? w_n_in : '0;
    w_rd_n   = w_yumi_instr ? w_need : 2'd0;
    if (redirect_v_i) begin
      w_wr_ent[0].data = redirect_instr_i;
      w_wr_ent[0].tag  = 1'b1;
      w_wr_n           = redirect_resume_i ? wn_w_lp'(1) : '0;
    end
  end

  bp_fe_parcel_queue #(
    .fetch_parcels_p  (fetch_parcels_p),
    .buffer_parcels_p (buffer_parcels_p)
  ) u_queue (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (w_clear),
    .wr_n_i    (w_wr_n),
    .wr_data_i (w_wr_ent),
    .rd_n_i    (w_rd_n),
    .h0_o      (w_h0),
    .h1_o      (w_h1),
    .count_o   (w_count)
  );

  assign count_o = w_count;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_head_pc     <= '0;
      r_exc_pending <= 1'b0;
      r_exc_pc      <= '0;
    end else begin
      if (redirect_v_i) begin
        if (redirect_resume_i) r_head_pc <= redirect_pc_i;
      end else if (w_wr_blk && (w_count == '0)) begin
        r_head_pc <= {if2_pc_i[vaddr_width_p-1:1], 1'b0};
      end else if (w_yumi_instr) begin
        r_head_pc <= r_head_pc + vaddr_width_p'({w_need, 1'b0});
      end

      if (w_clear) begin
        r_exc_pending <= 1'b0;
      end else if (w_accept && if2_exception_v_i) begin
        r_exc_pending <= 1'b1;
        r_exc_pc      <= if2_pc_i;
      end
    end
  end

  a_yumi_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (fetch_yumi_i && !redirect_v_i) |-> (fetch_v_o || fetch_exception_v_o));

endmodule

// File: tb/tb_bp_fe_parcel_realigner.sv
module tb_bp_fe_parcel_realigner;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if2_v, if2_exc;
  logic [38:0] if2_pc;
  logic [63:0] if2_data;
  logic        if2_ready;
  logic        redirect_v, redirect_resume;
  logic [15:0] redirect_instr;
  logic [38:0] redirect_pc;
  logic        fetch_v, fetch_exc_v, fetch_compressed, fetch_partial, fetch_yumi;
  logic [38:0] fetch_pc;
  logic [31:0] fetch_instr;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bp_fe_parcel_realigner #(
    .vaddr_width_p(39), .fetch_parcels_p(4), .buffer_parcels_p(8)
  ) dut (
    .clk_i               (clk),
    .reset_n_i           (reset_n),
    .if2_v_i             (if2_v),
    .if2_exception_v_i   (if2_exc),
    .if2_pc_i            (if2_pc),
    .if2_data_i          (if2_data),
    .if2_ready_o         (if2_ready),
    .redirect_v_i        (redirect_v),
    .redirect_resume_i   (redirect_resume),
    .redirect_instr_i    (redirect_instr),
    .redirect_pc_i       (redirect_pc),
    .fetch_v_o           (fetch_v),
    .fetch_exception_v_o (fetch_exc_v),
    .fetch_pc_o          (fetch_pc),
    .fetch_instr_o       (fetch_instr),
    .fetch_compressed_o  (fetch_compressed),
    .fetch_partial_o     (fetch_partial),
    .fetch_yumi_i        (fetch_yumi),
    .count_o             (count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if2_v = 0; if2_exc = 0; redirect_v = 0; redirect_resume = 0; fetch_yumi = 0;
  endtask

  task automatic blk(input logic [38:0] pc, input logic [15:0] d0, d1, d2, d3);
    if2_v = 1; if2_exc = 0; if2_pc = pc; if2_data = {d3, d2, d1, d0};
  endtask

  task automatic flush();
    idle(); redirect_v = 1; step(); idle();
  endtask

  initial begin
    reset_n = 0; idle();
    if2_pc = '0; if2_data = '0; redirect_instr = '0; redirect_pc = '0;
    #1;
    chk("rst_fetch_v", fetch_v, 0);
    chk("rst_exc_v", fetch_exc_v, 0);
    chk("rst_ready", if2_ready, 1);
    chk("rst_count", count, 0);
    step(); step();
    reset_n = 1;

    // Four compressed parcels, one per cycle
    blk(39'h1000, 16'h0001, 16'h4501, 16'h0405, 16'h8082);
    chk("t1_ready", if2_ready, 1);
    step(); idle();
    fetch_yumi = 1;
    chk("t1_v0", fetch_v, 1); chk("t1_pc0", fetch_pc, 39'h1000);
    chk("t1_i0", fetch_instr, 32'h0001); chk("t1_c0", fetch_compressed, 1);
    step();
    chk("t1_pc1", fetch_pc, 39'h1002); chk("t1_i1", fetch_instr, 32'h4501);
    step();
    chk("t1_pc2", fetch_pc, 39'h1004); chk("t1_i2", fetch_instr, 32'h0405);
    step();
    chk("t1_v3", fetch_v, 1); chk("t1_pc3", fetch_pc, 39'h1006);
    chk("t1_i3", fetch_instr, 32'h8082); chk("t1_c3", fetch_compressed, 1);
    step(); fetch_yumi = 0;
    chk("t1_empty_v", fetch_v, 0); chk("t1_empty_cnt", count, 0);

    // 32-bit instruction spanning two blocks
    blk(39'h1006, 16'h0000, 16'h0000, 16'h0000, 16'h0513);
    step(); idle();
    chk("t2_cnt1", count, 1); chk("t2_half_v", fetch_v, 0); chk("t2_half_exc", fetch_exc_v, 0);
    blk(39'h1008, 16'h0000, 16'h0001, 16'h0001, 16'h0001);
    step(); idle();
    chk("t2_v", fetch_v, 1); chk("t2_instr", fetch_instr, 32'h00000513);
    chk("t2_pc", fetch_pc, 39'h1006); chk("t2_partial", fetch_partial, 1);
    chk("t2_comp", fetch_compressed, 0); chk("t2_cnt", count, 5);
    fetch_yumi = 1; step(); fetch_yumi = 0;
    chk("t2_next_pc", fetch_pc, 39'h100a); chk("t2_next_cnt", count, 3);
    chk("t2_next_partial", fetch_partial, 0);
    flush();
    chk("t2_flush_cnt", count, 0);

    // Fill to full, drain back to the ready threshold
    blk(39'h1100, 16'h0001, 16'h0001, 16'h0001, 16'h0001); step();
    blk(39'h1108, 16'h0001, 16'h0001, 16'h0001, 16'h0001); step(); idle();
    chk("t3_cnt8", count, 8); chk("t3_rdy8", if2_ready, 0);
    fetch_yumi = 1; step();
    chk("t3_cnt7", count, 7); chk("t3_rdy7", if2_ready, 0);
    step(); step(); step(); fetch_yumi = 0;
    chk("t3_cnt4", count, 4); chk("t3_rdy4", if2_ready, 1);
    flush();

    // Redirect with resume; same-cycle block refused
    blk(39'h5000, 16'h0001, 16'h0001, 16'h0001, 16'h0001);
    redirect_v = 1; redirect_resume = 1; redirect_instr = 16'h0513; redirect_pc = 39'h2000;
    chk("t4_rdy_redir", if2_ready, 0);
    step(); idle();
    chk("t4_cnt1", count, 1); chk("t4_v", fetch_v, 0);
    blk(39'h2002, 16'hffff, 16'h0000, 16'h0001, 16'h0001);
    step(); idle();
    chk("t4_instr", fetch_instr, 32'h00000513); chk("t4_pc", fetch_pc, 39'h2000);
    chk("t4_partial", fetch_partial, 1); chk("t4_cnt", count, 4);
    flush();

    // Fault after a lone half instruction
    blk(39'h3006, 16'h0000, 16'h0000, 16'h0000, 16'h0013); step();
    if2_v = 1; if2_exc = 1; if2_pc = 39'h3008;
    step(); idle();
    chk("t5_exc_v", fetch_exc_v, 1); chk("t5_v", fetch_v, 0);
    chk("t5_pc", fetch_pc, 39'h3006); chk("t5_partial", fetch_partial, 1);
    chk("t5_rdy", if2_ready, 0);
    fetch_yumi = 1; step(); fetch_yumi = 0;
    chk("t5_cnt", count, 0); chk("t5_rdy_after", if2_ready, 1); chk("t5_exc_clr", fetch_exc_v, 0);

    // Fault on an empty queue
    if2_v = 1; if2_exc = 1; if2_pc = 39'h4000;
    step(); idle();
    chk("t5b_exc_v", fetch_exc_v, 1); chk("t5b_pc", fetch_pc, 39'h4000);
    chk("t5b_partial", fetch_partial, 0);
    fetch_yumi = 1; step(); fetch_yumi = 0;
    chk("t5b_exc_clr", fetch_exc_v, 0);

    // Async reset mid-cycle with count 5
    blk(39'h1000, 16'h0001, 16'h0001, 16'h0001, 16'h0001); step();
    blk(39'h1006, 16'h0000, 16'h0000, 16'h0000, 16'h0001); step(); idle();
    chk("t6_cnt5", count, 5);
    #2 reset_n = 0;
    #1;
    chk("t6_rst_v", fetch_v, 0); chk("t6_rst_cnt", count, 0); chk("t6_rst_rdy", if2_ready, 1);
    step(); reset_n = 1; step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
